// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decoder_pkg
// Purpose  : Shared widths and reference one-hot decode for the 3-to-8 decoder.
// Revision : 1.0
// ============================================================================
package decoder_pkg;

    localparam int DEC_IN_W  = 3;
    localparam int DEC_OUT_W = 8;

    // An unknown code decodes to all zeros, never to a partial one-hot.
    function automatic logic [DEC_OUT_W-1:0] onehot_decode(input logic [DEC_IN_W-1:0] code);
        logic [DEC_OUT_W-1:0] v;
        v = '0;
        if (!$isunknown(code)) begin
            for (int k = 0; k < DEC_OUT_W; k++) begin
                v[k] = (code == DEC_IN_W'(k));
            end
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder3x8_core.sv
`default_nettype none
// ============================================================================
// Module   : decoder3x8_core
// Purpose  : Combinational binary-to-one-hot decode with unknown-input squash.
// Revision : 1.0
// ============================================================================
module decoder3x8_core
    import decoder_pkg::*;
#(
    parameter int IN_W  = DEC_IN_W,
    parameter int OUT_W = 2**IN_W
) (
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out
);

    logic w_known;

    assign w_known = !$isunknown(in);

    for (genvar k = 0; k < OUT_W; k++) begin : g_line
        assign out[k] = w_known && (in == IN_W'(k));
    end

endmodule
`default_nettype wire

// File: rtl/decoder3x8_beh.sv
`default_nettype none
// ============================================================================
// Module   : decoder3x8_beh
// Purpose  : Registered 3-to-8 one-hot decoder with synchronous reset priority.
// Revision : 1.0
// ============================================================================
module decoder3x8_beh
    import decoder_pkg::*;
#(
    parameter int IN_W  = DEC_IN_W,
    parameter int OUT_W = 2**IN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out
);

    logic [OUT_W-1:0] w_next;
    logic [OUT_W-1:0] r_out;

    if (OUT_W != 2**IN_W) begin : g_bad_width
        $error("decoder3x8_beh: OUT_W must equal 2**IN_W");
    end

    decoder3x8_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .in  (in),
        .out (w_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            r_out <= w_next;
        end
    end

    assign out = r_out;

    a_reset_clears : assert property (@(posedge clk) rst |=> (out == '0));

    a_onehot : assert property (@(posedge clk) (!rst && !$isunknown(in)) |=> $onehot(out));

    if (IN_W == DEC_IN_W) begin : g_ref_check
        a_matches_ref : assert property (@(posedge clk)
            (!rst && !$isunknown(in)) |=> (out == onehot_decode($past(in))));
    end

endmodule
`default_nettype wire

// File: tb/tb_decoder3x8_beh.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder3x8_beh
// Purpose  : Directed and random checks of decoder3x8_beh against a shift model.
// Revision : 1.0
// ============================================================================
module tb_decoder3x8_beh;

    logic       clk;
    logic       rst;
    logic [2:0] in;
    logic [7:0] out;

    int         n_cmp;
    int         n_err;
    logic [7:0] prev_exp;
    bit         have_prev;

    decoder3x8_beh dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .out (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle: before the edge out must still show the previous result,
    // after the edge it must show the model's decode of what was just sampled.
    task automatic step(input logic r, input logic [2:0] code, input string tag);
        logic [7:0] exp;
        @(negedge clk);
        rst = r;
        in  = code;
        #1;
        if (have_prev) begin
            n_cmp++;
            assert (out === prev_exp) else begin
                n_err++;
                $error("FAIL %s-hold: out=%b expected=%b", tag, out, prev_exp);
            end
        end
        @(posedge clk);
        #1;
        if (r)                    exp = 8'h00;
        else if ($isunknown(code)) exp = 8'h00;
        else                      exp = 8'd1 << code;
        n_cmp++;
        assert (out === exp) else begin
            n_err++;
            $error("FAIL %s: in=%b rst=%b out=%b expected=%b", tag, code, r, out, exp);
        end
        prev_exp  = exp;
        have_prev = 1'b1;
    endtask

    initial begin
        logic [2:0] xcode;
        n_cmp     = 0;
        n_err     = 0;
        have_prev = 1'b0;
        prev_exp  = 8'h00;
        rst       = 1'b1;
        in        = 3'b101;
        xcode     = 3'b1x0;

        step(1'b1, 3'b101, "reset0");
        step(1'b1, 3'b101, "reset1");

        for (int i = 0; i < 8; i++) step(1'b0, 3'(i), "sweep");

        for (int i = 0; i < 6; i++) step(1'b0, (i % 2 == 0) ? 3'b000 : 3'b111, "toggle");

        step(1'b0, 3'b011, "mid_pre");
        step(1'b1, 3'b011, "mid_rst");
        step(1'b0, 3'b011, "mid_post");

        for (int i = 0; i < 5; i++) step(1'b0, 3'b110, "hold");

        step(1'b0, 3'b010, "x_pre");
        step(1'b0, xcode,  "x_in");
        step(1'b0, 3'b100, "x_post");

        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(9) == 0), 3'($urandom_range(7)), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
